// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: sequencer state encoding and the SIIC vector.
package cpu_defs;
  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_FLUSH  = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  // Address the PC block forces on an accepted SIIC.
  localparam logic [15:0] SIIC_VEC = 16'h0002;
  localparam int          CNT_W    = 3;
endpackage

// File: rtl/dff.sv
// Generic register with write enable and async active-high reset to RST_VAL.
module dff #(
  parameter int            W       = 16,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  // Load on enable, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       o_q <= RST_VAL;
    else if (i_en) o_q <= i_d;
  end
endmodule

// File: rtl/pc_ctrl_flush_cnt.sv
// Small up-counter with enable, clear and a terminal flag at TERM.
module flush_cnt
  import cpu_defs::*;
#(
  parameter logic [CNT_W-1:0] TERM = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_term
);
  // Clear has priority so the terminal cycle wraps straight back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        o_cnt <= '0;
    else if (i_clr) o_cnt <= '0;
    else if (i_en)  o_cnt <= o_cnt + 1'b1;
  end

  assign o_term = (o_cnt == TERM);
endmodule

// File: rtl/pc_ctrl.sv
// Next-PC sequencer: picks increment / redirect / stall / halt each cycle
// and tracks the exception return state.
module pc_ctrl
  import cpu_defs::*;
#(
  parameter int          FLUSH_CYC = 1,
  parameter logic [15:0] EPC_RST   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        BrTaken,
  input  logic        JmpImm,
  input  logic        JmpReg,
  input  logic        RtiReq,
  input  logic        SiicReq,
  input  logic        HaltReq,
  input  logic        MemStall,
  input  logic        HazStall,
  input  logic [15:0] PcInc2,
  output logic        PcSel,
  output logic        RegJmp,
  output logic        Halt,
  output logic        SIIC,
  output logic        RsSel,
  output logic        ImmZero,
  output logic        Flush,
  output logic [15:0] Epc,
  output logic        InExc,
  output logic        Halted
);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(FLUSH_CYC - 1);

  state_t r_state, w_nxt;
  logic   r_inexc;
  logic   w_stall, w_cnt_en, w_cnt_clr, w_cnt_term;
  logic   w_epc_we, w_exc_set, w_exc_clr;
  logic [CNT_W-1:0] w_cnt;

  assign w_stall = MemStall | HazStall;

  // Controls are combinational so the PC block sees them in the same cycle.
  always_comb begin
    PcSel     = 1'b0;
    RegJmp    = 1'b0;
    Halt      = 1'b0;
    SIIC      = 1'b0;
    RsSel     = 1'b0;
    ImmZero   = 1'b0;
    Flush     = 1'b0;
    w_nxt     = r_state;
    w_cnt_en  = 1'b0;
    w_cnt_clr = 1'b0;
    w_epc_we  = 1'b0;
    w_exc_set = 1'b0;
    w_exc_clr = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (SiicReq && !r_inexc) begin
          SIIC = 1'b1; Flush = 1'b1;
          w_epc_we = 1'b1; w_exc_set = 1'b1;
          w_nxt = ST_FLUSH;
        end else if (SiicReq || HaltReq) begin
          // Double fault or HALT: freeze the PC for good.
          Halt = 1'b1;
          w_nxt = ST_HALTED;
        end else if (RtiReq) begin
          // Return through the Rs+Imm path with Rs=Epc, Imm=0.
          RegJmp = 1'b1; RsSel = 1'b1; ImmZero = 1'b1; Flush = 1'b1;
          w_exc_clr = 1'b1;
          w_nxt = ST_FLUSH;
        end else if (JmpReg) begin
          RegJmp = 1'b1; Flush = 1'b1;
          w_nxt = ST_FLUSH;
        end else if (BrTaken || JmpImm) begin
          PcSel = 1'b1; Flush = 1'b1;
          w_nxt = ST_FLUSH;
        end else if (w_stall) begin
          Halt = 1'b1;
        end
      end
      ST_FLUSH: begin
        // Requests here come from wrong-path instructions and are dropped.
        Flush = 1'b1;
        if (w_stall) begin
          Halt = 1'b1;
        end else begin
          w_cnt_en = 1'b1;
          if (w_cnt_term) begin
            w_cnt_clr = 1'b1;
            w_nxt     = ST_RUN;
          end
        end
      end
      ST_HALTED: Halt = 1'b1;
      default:   w_nxt = ST_RUN;
    endcase
  end

  // State and in-exception flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_inexc <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_exc_set)      r_inexc <= 1'b1;
      else if (w_exc_clr) r_inexc <= 1'b0;
    end
  end

  assign InExc  = r_inexc;
  assign Halted = (r_state == ST_HALTED);

  flush_cnt #(.TERM(TERM)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_cnt_en),
    .i_clr (w_cnt_clr),
    .o_cnt (w_cnt),
    .o_term(w_cnt_term)
  );

  dff #(.W(16), .RST_VAL(EPC_RST)) u_epc (
    .clk (clk),
    .rst (rst),
    .i_en(w_epc_we),
    .i_d (PcInc2),
    .o_q (Epc)
  );
endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: two instances (FLUSH_CYC=1 and 3) share stimulus and are
// compared against a per-instance behavioural model of the sequencing rules.
module tb_pc_ctrl;
  localparam int B_PC = 6, B_RJ = 5, B_HT = 4, B_SI = 3, B_RS = 2, B_IZ = 1, B_FL = 0;
  localparam int FC [2] = '{1, 3};

  logic clk = 1'b0, rst = 1'b1;
  logic BrTaken = 0, JmpImm = 0, JmpReg = 0, RtiReq = 0, SiicReq = 0, HaltReq = 0;
  logic MemStall = 0, HazStall = 0;
  logic [15:0] PcInc2 = '0;
  logic [1:0] PcSel, RegJmp, Halt, SIIC, RsSel, ImmZero, Flush, InExc, Halted;
  logic [15:0] Epc [2];

  int checks = 0, errors = 0;

  // Model state: remaining flush cycles, halted, in-exception, saved EPC.
  int          m_left [2];
  bit          m_halt [2];
  bit          m_exc  [2];
  logic [15:0] m_epc  [2];

  always #5 clk = ~clk;

  pc_ctrl #(.FLUSH_CYC(1), .EPC_RST(16'h0000)) u1 (
    .clk(clk), .rst(rst), .BrTaken(BrTaken), .JmpImm(JmpImm), .JmpReg(JmpReg),
    .RtiReq(RtiReq), .SiicReq(SiicReq), .HaltReq(HaltReq), .MemStall(MemStall),
    .HazStall(HazStall), .PcInc2(PcInc2), .PcSel(PcSel[0]), .RegJmp(RegJmp[0]),
    .Halt(Halt[0]), .SIIC(SIIC[0]), .RsSel(RsSel[0]), .ImmZero(ImmZero[0]),
    .Flush(Flush[0]), .Epc(Epc[0]), .InExc(InExc[0]), .Halted(Halted[0]));

  pc_ctrl #(.FLUSH_CYC(3), .EPC_RST(16'h0000)) u3 (
    .clk(clk), .rst(rst), .BrTaken(BrTaken), .JmpImm(JmpImm), .JmpReg(JmpReg),
    .RtiReq(RtiReq), .SiicReq(SiicReq), .HaltReq(HaltReq), .MemStall(MemStall),
    .HazStall(HazStall), .PcInc2(PcInc2), .PcSel(PcSel[1]), .RegJmp(RegJmp[1]),
    .Halt(Halt[1]), .SIIC(SIIC[1]), .RsSel(RsSel[1]), .ImmZero(ImmZero[1]),
    .Flush(Flush[1]), .Epc(Epc[1]), .InExc(InExc[1]), .Halted(Halted[1]));

  task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [15:0] ctl(input int k);
    return {9'd0, PcSel[k], RegJmp[k], Halt[k], SIIC[k], RsSel[k], ImmZero[k], Flush[k]};
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_halt[k] = 0; m_exc[k] = 0; m_epc[k] = 16'h0000;
    end
  endfunction

  // Check every output against the model, then advance one clock.
  task automatic step();
    logic [6:0]  e      [2];
    int          n_left [2];
    bit          n_halt [2];
    bit          n_exc  [2];
    logic [15:0] n_epc  [2];
    bit stall;
    #1;
    stall = MemStall | HazStall;
    for (int k = 0; k < 2; k++) begin
      e[k] = '0;
      n_left[k] = m_left[k]; n_halt[k] = m_halt[k]; n_exc[k] = m_exc[k]; n_epc[k] = m_epc[k];
      if (m_halt[k]) begin
        e[k][B_HT] = 1'b1;
      end else if (m_left[k] > 0) begin
        e[k][B_FL] = 1'b1;
        if (stall) e[k][B_HT] = 1'b1;
        else       n_left[k] = m_left[k] - 1;
      end else if (SiicReq && !m_exc[k]) begin
        e[k][B_SI] = 1'b1; e[k][B_FL] = 1'b1;
        n_epc[k] = PcInc2; n_exc[k] = 1; n_left[k] = FC[k];
      end else if (SiicReq || HaltReq) begin
        e[k][B_HT] = 1'b1; n_halt[k] = 1;
      end else if (RtiReq) begin
        e[k][B_RJ] = 1'b1; e[k][B_RS] = 1'b1; e[k][B_IZ] = 1'b1; e[k][B_FL] = 1'b1;
        n_exc[k] = 0; n_left[k] = FC[k];
      end else if (JmpReg) begin
        e[k][B_RJ] = 1'b1; e[k][B_FL] = 1'b1; n_left[k] = FC[k];
      end else if (BrTaken || JmpImm) begin
        e[k][B_PC] = 1'b1; e[k][B_FL] = 1'b1; n_left[k] = FC[k];
      end else if (stall) begin
        e[k][B_HT] = 1'b1;
      end
      chk("ctl", k, ctl(k), {9'd0, e[k]});
      chk("epc", k, Epc[k], m_epc[k]);
      chk("inexc", k, {15'd0, InExc[k]}, {15'd0, m_exc[k]});
      chk("halted", k, {15'd0, Halted[k]}, {15'd0, m_halt[k]});
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_left[k] = n_left[k]; m_halt[k] = n_halt[k]; m_exc[k] = n_exc[k]; m_epc[k] = n_epc[k];
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit br, ji, jr, rti, si, hl, ms, hs, input logic [15:0] pc);
    BrTaken = br; JmpImm = ji; JmpReg = jr; RtiReq = rti; SiicReq = si; HaltReq = hl;
    MemStall = ms; HazStall = hs; PcInc2 = pc;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
  endtask

  // Reset pulse asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    BrTaken = 0; JmpImm = 0; JmpReg = 0; RtiReq = 0; SiicReq = 0; HaltReq = 0;
    MemStall = 0; HazStall = 0;
    rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      chk("rst_ctl", k, ctl(k), 16'h0);
      chk("rst_epc", k, Epc[k], 16'h0000);
      chk("rst_inexc", k, {15'd0, InExc[k]}, 16'h0);
      chk("rst_halted", k, {15'd0, Halted[k]}, 16'h0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    idle(4);

    // Branch, then a wrong-path branch during flush, then idle.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 16'h0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 16'h0);
    idle(4);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 16'h0);
    idle(4);

    // SIIC, RTI, then SIIC followed by a double fault held in HALTED.
    drive(0, 0, 0, 0, 1, 0, 0, 0, 16'h0046);
    idle(4);
    drive(0, 0, 0, 1, 0, 0, 0, 0, 16'h0);
    idle(4);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 16'h0100);
    idle(4);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 16'h0200);
    drive(1, 0, 1, 1, 0, 0, 0, 0, 16'h0);
    idle(10);
    do_reset();

    // Stalls in RUN, redirect beating a stall, stall inside flush, RTI outside exception.
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 1, 0, 16'h0);
    drive(0, 0, 1, 0, 0, 0, 1, 0, 16'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 16'h0);
    idle(4);
    drive(0, 0, 0, 1, 0, 0, 0, 0, 16'h0);
    idle(4);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 16'h0);
    idle(2);
    do_reset();

    // Async reset in the middle of the FLUSH_CYC=3 flush window.
    drive(0, 0, 0, 0, 1, 0, 0, 0, 16'h0046);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_flush", 1, {15'd0, Flush[1]}, 16'h0);
    chk("async_epc", 1, Epc[1], 16'h0000);
    chk("async_inexc", 1, {15'd0, InExc[1]}, 16'h0);
    chk("async_cnt", 1, {13'd0, u3.u_cnt.o_cnt}, 16'h0);
    @(negedge clk);
    do_reset();

    // Randomized traffic; reset whenever both instances have halted.
    for (int i = 0; i < 600; i++) begin
      if (m_halt[0] && m_halt[1]) do_reset();
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 13) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
            16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Sequencing controller for the program-counter block.
- Each cycle it decides the next-PC action: increment, PC-relative branch/jump, register jump, RTI return, SIIC exception vector, hold (stall) or halt.
- Drives the PC block's one-hot control inputs (PcSel, RegJmp, Halt, SIIC), pipeline flush, and the exception-return state (EPC, in-exception flag).
- Sits between fetch/decode/execute request sources and the PC datapath.

Parameters:
- FLUSH_CYC, 1, number of cycles Flush stays asserted after the redirect cycle (1..7).
- EPC_RST, 16'h0000, reset value of Epc.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- BrTaken  in  1  conditional branch resolved taken (PC+2+Imm).
- JmpImm  in  1  unconditional PC-relative jump (J/JAL).
- JmpReg  in  1  register jump (JR/JALR, Rs+Imm).
- RtiReq  in  1  RTI executing.
- SiicReq  in  1  SIIC executing or illegal instruction.
- HaltReq  in  1  HALT instruction reached commit point.
- MemStall  in  1  instruction memory not ready.
- HazStall  in  1  load-use stall from hazard unit.
- PcInc2  in  16  PC+2 of the instruction raising SiicReq.
- PcSel  out  1  select PC+2+Imm.
- RegJmp  out  1  select Rs+Imm.
- Halt  out  1  hold PC.
- SIIC  out  1  force PC to 0x0002.
- RsSel  out  1  steer Epc onto the PC block's Rs input.
- ImmZero  out  1  force the PC block's Imm input to 0.
- Flush  out  1  kill wrong-path instructions in IF/ID.
- Epc  out  16  saved exception return address.
- InExc  out  1  exception handler active.
- Halted  out  1  processor halted.

Behaviour:
- Reset state: RUN. Outputs: Epc=EPC_RST, InExc=0, Halted=0, Flush=0, flush counter=0.
- Control outputs are combinational from state and requests. This gives zero latency to the PC block, which registers on the same edge.
- Invariant: at most one of PcSel/RegJmp/Halt/SIIC is high in any cycle. All low means PC+2.
- States: RUN, FLUSH, HALTED.
- RUN priority, highest first:
  1. SiicReq with InExc=0: SIIC=1, Flush=1. Epc<=PcInc2, InExc<=1. Next state FLUSH.
  2. SiicReq with InExc=1 (double fault): Halt=1. Next state HALTED.
  3. HaltReq: Halt=1. Next state HALTED.
  4. RtiReq: RegJmp=1, RsSel=1, ImmZero=1, Flush=1. InExc<=0. Next state FLUSH. RTI with InExc=0 still returns to the current Epc.
  5. JmpReg: RegJmp=1, Flush=1. Next state FLUSH.
  6. BrTaken or JmpImm: PcSel=1, Flush=1. Next state FLUSH.
  7. MemStall or HazStall: Halt=1. Stay in RUN.
  8. Otherwise: all low (increment).
- Redirects win over stalls in the same cycle. The target is latched into the PC regardless of MemStall.
- FLUSH:
  - Flush=1.
  - All redirect, halt and SIIC requests are ignored (they come from wrong-path instructions).
  - MemStall/HazStall give Halt=1 and freeze the counter.
  - Otherwise PC increments and the counter increments.
  - When counter==FLUSH_CYC-1 and no stall, the counter clears and the next state is RUN.
  - Total Flush duration = redirect cycle + FLUSH_CYC non-stalled cycles.
- HALTED: Halt=1, Halted=1, all other controls 0. Exits only on rst.
- Asynchronous rst mid-FLUSH or in HALTED: immediately returns to reset values. The PC block resets in parallel.
- Epc is written only on an accepted SIIC. It is not written on a double fault.

Decomposition:
- Shared package (cpu_defs):
  - state encoding constants: RUN=2'b00, FLUSH=2'b01, HALTED=2'b10.
  - SIIC vector constant 16'h0002.
- One sub-module, flush_cnt: 3-bit counter with enable, clear and terminal flag. Also reusable by the hazard unit.
- The Epc register uses the existing 16-bit dff.

Test Plan:
- Reset then 4 idle cycles -> all controls 0, Epc=0x0000, InExc=0, Halted=0. PC sequence 0,2,4,6,8.
- BrTaken=1 for one cycle with FLUSH_CYC=1 -> PcSel=1 and Flush=1 that cycle. Flush=1 the next cycle. BrTaken asserted during FLUSH is ignored. RUN in cycle 3.
- SiicReq with PcInc2=0x0046 -> SIIC=1 and PC=0x0002 next cycle, Epc=0x0046, InExc=1. A later RtiReq -> RegJmp=1, RsSel=1, ImmZero=1. Next PC=0x0046, InExc=0.
- A second SiicReq while InExc=1 -> Halt=1, state HALTED, Epc unchanged. Halt held for 10+ cycles until rst.
- MemStall=1 for 3 cycles in RUN -> Halt=1 each cycle, PC held. JmpReg together with MemStall -> RegJmp=1, Halt=0.
- rst asserted mid-FLUSH with FLUSH_CYC=3 -> Flush and the counter clear asynchronously. Epc returns to 0x0000 without waiting for a clock edge.
